// File: rtl/jtframe_joyser_pkg.sv
// Shared constants for the serial joystick reader: scan geometry, per-player
// contact offsets within the 24-bit scan, and the scan FSM encoding.
package jtframe_joyser_pkg;

    localparam int unsigned NBITS           = 24;
    localparam int unsigned BITS_PER_PLAYER = 12;

    // Contact offsets inside one player's 12-bit group
    localparam int unsigned OFS_UP    = 0;
    localparam int unsigned OFS_DOWN  = 1;
    localparam int unsigned OFS_LEFT  = 2;
    localparam int unsigned OFS_RIGHT = 3;
    localparam int unsigned OFS_B1    = 4;
    localparam int unsigned OFS_START = 10;
    localparam int unsigned OFS_COIN  = 11;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StLo   = 3'd2,
        StHi   = 3'd3,
        StDone = 3'd4
    } state_t;

endpackage

// File: rtl/jtframe_joyser_if.sv
// Adapter-side bus of a 74165-style shift-register chain: load strobe,
// shift clock and serial data return.
interface jtframe_joyser_if;

    logic sr_load;
    logic sr_clk;
    logic sr_data;

    modport master (
        output sr_load,
        output sr_clk,
        input  sr_data
    );

    modport slave (
        input  sr_load,
        input  sr_clk,
        output sr_data
    );

endinterface

// File: rtl/jtframe_joyser.sv
// Serial arcade joystick reader: scans 24 active-low contacts every PERIOD
// cycles, debounces across two equal scans and presents active-high words.
module jtframe_joyser
    import jtframe_joyser_pkg::*;
#(
    parameter int unsigned CLKDIV = 8,
    parameter int unsigned PERIOD = 48000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    jtframe_joyser_if.master    sr,
    output logic [15:0]         board_joy1,
    output logic [15:0]         board_joy2,
    output logic [3:0]          board_coin,
    output logic [3:0]          board_start,
    output logic                scan_done
);

    localparam int unsigned PW = $clog2(PERIOD);
    localparam int unsigned TW = $clog2(CLKDIV);

    state_t             r_state;
    logic [PW-1:0]      r_period;
    logic [TW-1:0]      r_tick;
    logic [4:0]         r_bitcnt;
    logic [NBITS-1:0]   r_shreg;
    logic [NBITS-1:0]   r_prev;
    logic               r_sr_load;
    logic               r_sr_clk;
    logic               r_scan_done;
    logic [15:0]        r_joy1;
    logic [15:0]        r_joy2;
    logic [3:0]         r_coin;
    logic [3:0]         r_start;

    logic               w_wrap;
    logic               w_tick_end;
    logic [NBITS-1:0]   w_raw;

    // Reorder one player's 12 contacts into the board joystick layout
    function automatic logic [15:0] map_joy(input logic [BITS_PER_PLAYER-1:0] p);
        logic [15:0] j;
        j      = '0;
        j[3]   = p[OFS_UP];
        j[2]   = p[OFS_DOWN];
        j[1]   = p[OFS_LEFT];
        j[0]   = p[OFS_RIGHT];
        j[9:4] = p[OFS_B1 +: 6];
        return j;
    endfunction

    assign w_wrap     = (r_period == PW'(PERIOD - 1));
    assign w_tick_end = (r_tick == TW'(CLKDIV - 1));
    assign w_raw      = ~r_shreg;

    // Period counter, scan FSM, strobes and debounced outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_period    <= '0;
            r_tick      <= '0;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_prev      <= '0;
            r_sr_load   <= 1'b1;
            r_sr_clk    <= 1'b0;
            r_scan_done <= 1'b0;
            r_joy1      <= '0;
            r_joy2      <= '0;
            r_coin      <= '0;
            r_start     <= '0;
        end else begin
            r_period    <= w_wrap ? '0 : r_period + 1'b1;
            r_scan_done <= 1'b0;
            if (!enable) begin
                // Abandon any partial scan; the period counter keeps running
                r_state   <= StIdle;
                r_tick    <= '0;
                r_bitcnt  <= '0;
                r_sr_load <= 1'b1;
                r_sr_clk  <= 1'b0;
                r_prev    <= '0;
                r_joy1    <= '0;
                r_joy2    <= '0;
                r_coin    <= '0;
                r_start   <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_tick <= '0;
                        if (w_wrap) begin
                            r_state   <= StLoad;
                            r_sr_load <= 1'b0;
                        end
                    end
                    StLoad: begin
                        if (w_tick_end) begin
                            r_state   <= StLo;
                            r_tick    <= '0;
                            r_bitcnt  <= '0;
                            r_sr_load <= 1'b1;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    StLo: begin
                        if (w_tick_end) begin
                            r_shreg[r_bitcnt] <= sr.sr_data;
                            r_tick            <= '0;
                            if (r_bitcnt == 5'(NBITS - 1)) begin
                                r_state <= StDone;
                            end else begin
                                r_state  <= StHi;
                                r_sr_clk <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    StHi: begin
                        if (w_tick_end) begin
                            r_state  <= StLo;
                            r_tick   <= '0;
                            r_sr_clk <= 1'b0;
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    StDone: begin
                        // Only accept a scan that matches the previous one
                        if (w_raw == r_prev) begin
                            r_joy1  <= map_joy(w_raw[BITS_PER_PLAYER-1:0]);
                            r_joy2  <= map_joy(w_raw[NBITS-1:BITS_PER_PLAYER]);
                            r_coin  <= {2'b00,
                                        w_raw[BITS_PER_PLAYER + OFS_COIN],
                                        w_raw[OFS_COIN]};
                            r_start <= {2'b00,
                                        w_raw[BITS_PER_PLAYER + OFS_START],
                                        w_raw[OFS_START]};
                        end
                        r_prev      <= w_raw;
                        r_scan_done <= 1'b1;
                        r_tick      <= '0;
                        r_state     <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_tick  <= '0;
                    end
                endcase
            end
        end
    end

    assign sr.sr_load  = r_sr_load;
    assign sr.sr_clk   = r_sr_clk;
    assign scan_done   = r_scan_done;
    assign board_joy1  = r_joy1;
    assign board_joy2  = r_joy2;
    assign board_coin  = r_coin;
    assign board_start = r_start;

endmodule

// File: tb/tb_jtframe_joyser.sv
// Directed bench for jtframe_joyser with a 74165 adapter model.
module tb_jtframe_joyser;

    localparam int unsigned CLKDIV = 4;
    localparam int unsigned PERIOD = 400;
    localparam int unsigned FIRST_SCAN = PERIOD + 48 * CLKDIV + 1;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] board_joy1;
    logic [15:0] board_joy2;
    logic [3:0]  board_coin;
    logic [3:0]  board_start;
    logic        scan_done;

    jtframe_joyser_if sr ();

    jtframe_joyser #(
        .CLKDIV (CLKDIV),
        .PERIOD (PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sr          (sr.master),
        .board_joy1  (board_joy1),
        .board_joy2  (board_joy2),
        .board_coin  (board_coin),
        .board_start (board_start),
        .scan_done   (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adapter model: contacts pressed = 1 here, pins read back active low
    logic [23:0] pressed;
    logic [23:0] a_latch;
    logic [4:0]  a_idx;
    logic        a_last_clk;

    initial begin
        a_latch    = 24'hFFFFFF;
        a_idx      = '0;
        a_last_clk = 1'b0;
    end

    always @(posedge clk) begin
        a_last_clk <= sr.sr_clk;
        if (!sr.sr_load) begin
            a_latch <= ~pressed;
            a_idx   <= '0;
        end else if (sr.sr_clk && !a_last_clk) begin
            a_idx <= a_idx + 1'b1;
        end
    end

    assign sr.sr_data = a_latch[a_idx];

    int n_checks;
    int n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] j1, input logic [15:0] j2,
                              input logic [3:0] c, input logic [3:0] s);
        check({tag, ".joy1"}, 32'(board_joy1), 32'(j1));
        check({tag, ".joy2"}, 32'(board_joy2), 32'(j2));
        check({tag, ".coin"}, 32'(board_coin), 32'(c));
        check({tag, ".start"}, 32'(board_start), 32'(s));
    endtask

    // Wait for the next scan_done, measuring cycles and sr_clk activity
    task automatic wait_scan(output int cycles, output int rises, output int wmin,
                             output int wmax);
        logic last;
        int   hw;
        cycles = 0;
        rises  = 0;
        wmin   = 1000;
        wmax   = 0;
        hw     = 0;
        last   = 1'b0;
        forever begin
            @(negedge clk);
            cycles++;
            if (sr.sr_clk) begin
                if (!last) rises++;
                hw++;
            end else if (last) begin
                if (hw < wmin) wmin = hw;
                if (hw > wmax) wmax = hw;
                hw = 0;
            end
            last = sr.sr_clk;
            if (scan_done) break;
            if (cycles > int'(2 * PERIOD + 20)) begin
                n_checks++;
                n_err++;
                $display("FAIL scan_timeout: got no scan_done expected one within %0d cycles",
                         2 * PERIOD + 20);
                break;
            end
        end
    endtask

    task automatic scan();
        int c, r, mn, mx;
        wait_scan(c, r, mn, mx);
    endtask

    typedef struct {
        logic [23:0] pressed;
        logic [15:0] j1;
        logic [15:0] j2;
        logic [3:0]  coin;
        logic [3:0]  start;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc, rises, wmin, wmax, cnt;
        logic [15:0] pj1, pj2;
        logic [3:0]  pc, ps;

        n_checks = 0;
        n_err    = 0;

        vecs[0] = '{24'h000000, 16'h0000, 16'h0000, 4'h0, 4'h0};
        vecs[1] = '{24'h000001, 16'h0008, 16'h0000, 4'h0, 4'h0};
        vecs[2] = '{24'h800010, 16'h0010, 16'h0000, 4'h2, 4'h0};
        vecs[3] = '{24'h000000, 16'h0000, 16'h0000, 4'h0, 4'h0};
        vecs[4] = '{24'h20400A, 16'h0005, 16'h0202, 4'h0, 4'h0};
        vecs[5] = '{24'h001E00, 16'h0200, 16'h0008, 4'h1, 4'h1};
        vecs[6] = '{24'hFFFFFF, 16'h03FF, 16'h03FF, 4'h3, 4'h3};

        rst     = 1'b1;
        enable  = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        check("rst.sr_load", 32'(sr.sr_load), 32'd1);
        check("rst.sr_clk", 32'(sr.sr_clk), 32'd0);
        check("rst.scan_done", 32'(scan_done), 32'd0);
        check_outs("rst", 16'h0, 16'h0, 4'h0, 4'h0);

        // First scan after reset release and steady-state scan shape
        rst = 1'b0;
        wait_scan(cyc, rises, wmin, wmax);
        check("first_scan_cycles", 32'(cyc), 32'(FIRST_SCAN));
        wait_scan(cyc, rises, wmin, wmax);
        check("period_cycles", 32'(cyc), 32'(PERIOD));
        check("sr_clk_pulses", 32'(rises), 32'd23);
        check("sr_clk_wmin", 32'(wmin), 32'(CLKDIV));
        check("sr_clk_wmax", 32'(wmax), 32'(CLKDIV));
        check_outs("idle", 16'h0, 16'h0, 4'h0, 4'h0);

        // Each vector held for two scans: old value after one, new after two
        pj1 = '0; pj2 = '0; pc = '0; ps = '0;
        for (int i = 0; i < 7; i++) begin
            pressed = vecs[i].pressed;
            scan();
            check_outs($sformatf("v%0d.first", i), pj1, pj2, pc, ps);
            scan();
            check_outs($sformatf("v%0d.second", i), vecs[i].j1, vecs[i].j2,
                       vecs[i].coin, vecs[i].start);
            pj1 = vecs[i].j1; pj2 = vecs[i].j2; pc = vecs[i].coin; ps = vecs[i].start;
        end

        // Single-scan glitch on p2 start must never reach the outputs
        pressed = '0;
        scan();
        scan();
        check_outs("glitch.base", 16'h0, 16'h0, 4'h0, 4'h0);
        pressed = 24'h400000;
        scan();
        check("glitch.s1.start", 32'(board_start), 32'h0);
        pressed = '0;
        scan();
        check("glitch.s2.start", 32'(board_start), 32'h0);
        scan();
        check("glitch.s3.start", 32'(board_start), 32'h0);

        // Drop enable while in HI with bitcnt=10
        pressed = 24'hFFFFFF;
        scan();
        scan();
        check_outs("en.pre", 16'h03FF, 16'h03FF, 4'h3, 4'h3);
        cnt = 0;
        for (int k = 0; k < int'(2 * PERIOD); k++) begin
            logic was;
            was = sr.sr_clk;
            @(negedge clk);
            if (sr.sr_clk && !was) cnt++;
            if (cnt == 11) break;
        end
        check("en.reached_hi10", 32'(cnt), 32'd11);
        enable = 1'b0;
        @(negedge clk);
        check("en.sr_clk", 32'(sr.sr_clk), 32'd0);
        check("en.sr_load", 32'(sr.sr_load), 32'd1);
        check_outs("en.off", 16'h0, 16'h0, 4'h0, 4'h0);
        cnt = 0;
        for (int k = 0; k < int'(2 * PERIOD); k++) begin
            if (scan_done) cnt++;
            @(negedge clk);
        end
        check("en.no_scan_done", 32'(cnt), 32'd0);
        enable = 1'b1;
        scan();
        check_outs("en.re1", 16'h0, 16'h0, 4'h0, 4'h0);
        scan();
        check_outs("en.re2", 16'h03FF, 16'h03FF, 4'h3, 4'h3);

        // Asynchronous reset in the middle of an LO tick
        scan();
        cnt = 0;
        for (int k = 0; k < int'(2 * PERIOD); k++) begin
            @(negedge clk);
            if (!sr.sr_load) cnt = 1;
            else if (cnt == 1) break;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rlo.sr_load", 32'(sr.sr_load), 32'd1);
        check("rlo.sr_clk", 32'(sr.sr_clk), 32'd0);
        check("rlo.scan_done", 32'(scan_done), 32'd0);
        check_outs("rlo", 16'h0, 16'h0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_scan(cyc, rises, wmin, wmax);
        check("rlo.first_scan_cycles", 32'(cyc), 32'(FIRST_SCAN));
        check("rlo.sr_clk_pulses", 32'(rises), 32'd23);
        check_outs("rlo.s1", 16'h0, 16'h0, 4'h0, 4'h0);
        scan();
        check_outs("rlo.s2", 16'h03FF, 16'h03FF, 4'h3, 4'h3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
